// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the line-fill requester.
// Holds the FSM state enum, the read tag and the line geometry.
package bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_REQ,
      S_RESP,
      S_DONE
   } state_t;

   localparam int          LINE_BEATS   = 8;
   localparam int          BEAT_CNT_W   = 3;
   localparam logic [12:0] TAG_READ_MEM = 13'h0001;

   // Clear the byte offset inside a 64-byte line.
   function automatic logic [63:0] line_align(input logic [63:0] a);
      return {a[63:6], 6'b0};
   endfunction

endpackage

// File: rtl/bus_requester.sv
// bus_requester: arbitrates for the bus, issues one line read and
// assembles the returned beats into a full line for the client.
module bus_requester #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int LINE_BEATS     = bus_pkg::LINE_BEATS
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 req_valid,
   input  logic [63:0]                          req_addr,
   output logic                                 req_ready,
   output logic                                 resp_valid,
   output logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] resp_data,
   output logic                                 bus_reqcyc,
   input  logic                                 bus_grant,
   output logic                                 bus_busy,
   output logic [BUS_DATA_WIDTH-1:0]            bus_req,
   output logic [BUS_TAG_WIDTH-1:0]             bus_reqtag,
   input  logic                                 bus_reqack,
   input  logic                                 bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0]            bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]             bus_resptag,
   output logic                                 bus_respack
);

   import bus_pkg::*;

   state_t                              r_state;
   state_t                              w_next;
   logic [63:0]                         r_addr;
   logic [BEAT_CNT_W-1:0]               r_cnt;
   logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] r_line;
   logic                                w_accept;
   logic                                w_beat;
   logic                                w_last;
   logic                                w_unused_tag;

   // Response tags are not used to qualify beats.
   assign w_unused_tag = ^bus_resptag;

   assign w_accept = (r_state == S_IDLE) && req_valid;
   assign w_beat   = (r_state == S_RESP) && bus_respcyc;
   assign w_last   = w_beat &&
                     (r_cnt == BEAT_CNT_W'(LINE_BEATS - 1));

   assign resp_data = r_line;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and Moore/Mealy outputs; everything idles at 0.
   always_comb begin
      w_next      = r_state;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      bus_reqcyc  = 1'b0;
      bus_busy    = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      bus_respack = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_next = S_ARB;
            end
         end
         S_ARB: begin
            bus_reqcyc = 1'b1;
            if (bus_grant) begin
               w_next = S_REQ;
            end
         end
         S_REQ: begin
            bus_reqcyc = 1'b1;
            bus_busy   = 1'b1;
            bus_req    = BUS_DATA_WIDTH'(r_addr);
            bus_reqtag = BUS_TAG_WIDTH'(TAG_READ_MEM);
            if (bus_reqack) begin
               w_next = S_RESP;
            end
         end
         S_RESP: begin
            bus_busy    = 1'b1;
            bus_respack = bus_respcyc;
            if (w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            resp_valid = 1'b1;
            w_next     = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Address latch, beat counter and line assembly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr <= '0;
         r_cnt  <= '0;
         r_line <= '0;
      end else begin
         if (w_accept) begin
            r_addr <= line_align(req_addr);
         end
         if (w_beat) begin
            r_line[BUS_DATA_WIDTH*int'(r_cnt) +: BUS_DATA_WIDTH] <= bus_resp;
            r_cnt <= w_last ? '0 : r_cnt + BEAT_CNT_W'(1);
         end
      end
   end

endmodule
